// File: rtl/step_rate_ticker.sv
// Count-enable source for the hex-display counter: divided-clock ticks when running, one tick per debounced press when paused.
// Latency: tick registered one edge after the divider reaches zero; step tick DEBOUNCE_CYCLES+2 edges after first key sample.
// Backpressure: none; tick is a fire-and-forget single-cycle pulse.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   reset    - synchronous active-high reset
//   run      - 1 = free-running divider, 0 = paused / single-step
//   rate_sel - 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//   step_n   - raw asynchronous push-button, active-low
//   tick     - registered one-cycle enable pulse
//   running  - registered copy of run
module step_rate_ticker #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 28,
  parameter int DB_W            = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] rate_sel,
  input  logic       step_n,
  output logic       tick,
  output logic       running
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Count value loaded at the start of each period; period is reload+1 edges.
  function automatic logic [CNT_W-1:0] reload(input logic [1:0] sel);
    logic [CNT_W-1:0] r;
    case (sel)
      2'b00:   r = '0;
      2'b01:   r = CNT_W'(CLK_HZ - 1);
      2'b10:   r = CNT_W'(2 * CLK_HZ - 1);
      default: r = CNT_W'(4 * CLK_HZ - 1);
    endcase
    return r;
  endfunction

  // Divider state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rate_q, rate_d;
  logic             div_tick;

  // Key path state
  logic             s1_q, s2_q;
  logic             db_lvl_q, db_lvl_d;   // debounced key level
  logic             db_dly_q;             // debounced level one edge ago
  logic [DB_W-1:0]  dbcnt_q, dbcnt_d;
  logic             press;

  // Output registers
  logic             tick_q, tick_d;
  logic             running_q;

  // Divider next state. A rate change restarts the period even while running,
  // and pausing pins the count at full period so resuming starts fresh.
  always_comb begin
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    div_tick = 1'b0;
    if (rate_sel != rate_q) begin
      cnt_d  = reload(rate_sel);
      rate_d = rate_sel;
    end else if (!run) begin
      cnt_d = reload(rate_sel);
    end else if (cnt_q == '0) begin
      div_tick = 1'b1;
      cnt_d    = reload(rate_sel);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Debounce: level only changes after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample clears the run.
  always_comb begin
    dbcnt_d  = dbcnt_q;
    db_lvl_d = db_lvl_q;
    if (s2_q == db_lvl_q) begin
      dbcnt_d = '0;
    end else if (dbcnt_q == DB_LAST) begin
      db_lvl_d = s2_q;
      dbcnt_d  = '0;
    end else begin
      dbcnt_d = dbcnt_q + DB_W'(1);
    end
  end

  // Press is the falling edge of the debounced level; releases never tick.
  assign press  = db_dly_q & ~db_lvl_q;
  // Presses during run are dropped, not queued.
  assign tick_d = (run & div_tick) | (~run & press);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= reload(rate_sel);
      rate_q    <= rate_sel;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      db_lvl_q  <= 1'b1;
      db_dly_q  <= 1'b1;
      dbcnt_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rate_q    <= rate_d;
      s1_q      <= step_n;
      s2_q      <= s1_q;
      db_lvl_q  <= db_lvl_d;
      db_dly_q  <= db_lvl_q;
      dbcnt_q   <= dbcnt_d;
      tick_q    <= tick_d;
      running_q <= run;
    end
  end

  assign tick    = tick_q;
  assign running = running_q;

endmodule
